// File: rtl/sram_uart_transmitter_if.sv
// rtl/sram_uart_transmitter_if.sv - command and SRAM read bus of the SRAM-to-UART dump unit
//
// Purpose: groups the command handshake (Start/Start_address/Word_count/Busy/Done)
//          and the SRAM read port (SRAM_address/SRAM_read_data/SRAM_we_n).
// Modports:
//   master - system side: issues commands, returns SRAM read data
//   slave  - dump unit: accepts commands, drives the SRAM address
interface sram_uart_transmitter_if;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic        Busy;
  logic        Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;

  modport master (
    output Start, Start_address, Word_count, SRAM_read_data,
    input  Busy, Done, SRAM_address, SRAM_we_n
  );

  modport slave (
    input  Start, Start_address, Word_count, SRAM_read_data,
    output Busy, Done, SRAM_address, SRAM_we_n
  );
endinterface

// File: rtl/sram_uart_transmitter.sv
// rtl/sram_uart_transmitter.sv - streams SRAM words out of UART_TX_O as 8N1 bytes, high byte first
//
// Purpose: on Start, reads Word_count 16-bit words beginning at Start_address and
//          sends each as two back-to-back 8N1 frames (high byte, then low byte).
// Ports:
//   CLOCK_50_I - 50 MHz system clock
//   resetn     - asynchronous active-low reset
//   bus        - command + SRAM read bus (slave side)
//   UART_TX_O  - registered serial line, idle high
module sram_uart_transmitter #(
  parameter int BAUD_DIV          = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic                          CLOCK_50_I,
  input  logic                          resetn,
  sram_uart_transmitter_if.slave        bus,
  output logic                          UART_TX_O
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int LW = $clog2(SRAM_READ_LATENCY + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [LW-1:0] WAIT_LAST = LW'(SRAM_READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_FINISH
  } tx_state_t;

  tx_state_t     state;
  logic [17:0]   cur_addr;
  logic [17:0]   remaining;
  logic [17:0]   sram_addr_r;
  logic [7:0]    lo_byte;     // low half of the word; the high half goes straight to the serializer
  logic [8:0]    shift;       // bits still to go after the one on the line: data LSB first, then stop
  logic [3:0]    bit_idx;     // 0 = start bit on the line, 9 = stop bit on the line
  logic [BW-1:0] baud_cnt;
  logic [LW-1:0] wait_cnt;
  logic          busy_r;
  logic          done_r;
  logic          frame_end;

  assign frame_end = (baud_cnt == BAUD_LAST) && (bit_idx == 4'd9);

  assign bus.SRAM_address = sram_addr_r;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.Busy         = busy_r;
  assign bus.Done         = done_r;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state       <= S_TX_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      sram_addr_r <= '0;
      lo_byte     <= '0;
      shift       <= '1;
      bit_idx     <= '0;
      baud_cnt    <= '0;
      wait_cnt    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      UART_TX_O   <= 1'b1;
    end else begin
      done_r <= 1'b0;

      // Bit timing runs only while a frame is on the line; a new byte load
      // below overrides these assignments on the frame boundary.
      if (state == S_TX_SEND_HI || state == S_TX_SEND_LO) begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          if (bit_idx != 4'd9) begin
            UART_TX_O <= shift[0];
            shift     <= {1'b1, shift[8:1]};
            bit_idx   <= bit_idx + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end

      case (state)
        S_TX_IDLE: begin
          // A Start coinciding with the Done cycle is dropped, not queued.
          if (bus.Start && !done_r) begin
            cur_addr  <= bus.Start_address;
            remaining <= bus.Word_count;
            busy_r    <= 1'b1;
            if (bus.Word_count == 18'd0) begin
              state <= S_TX_FINISH;
            end else begin
              sram_addr_r <= bus.Start_address;
              state       <= S_TX_READ;
            end
          end
        end

        S_TX_READ: begin
          wait_cnt <= '0;
          state    <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            // Loading the high byte on the capture edge keeps the inter-word
            // idle gap to exactly READ + WAIT cycles.
            lo_byte   <= bus.SRAM_read_data[7:0];
            UART_TX_O <= 1'b0;
            shift     <= {1'b1, bus.SRAM_read_data[15:8]};
            bit_idx   <= '0;
            baud_cnt  <= '0;
            state     <= S_TX_SEND_HI;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_TX_SEND_HI: begin
          if (frame_end) begin
            // Stop bit flows directly into the next start bit.
            UART_TX_O <= 1'b0;
            shift     <= {1'b1, lo_byte};
            bit_idx   <= '0;
            baud_cnt  <= '0;
            state     <= S_TX_SEND_LO;
          end
        end

        S_TX_SEND_LO: begin
          if (frame_end) begin
            bit_idx   <= '0;
            cur_addr  <= cur_addr + 18'd1;
            remaining <= remaining - 18'd1;
            if (remaining == 18'd1) begin
              state <= S_TX_FINISH;
            end else begin
              sram_addr_r <= cur_addr + 18'd1;
              state       <= S_TX_READ;
            end
          end
        end

        S_TX_FINISH: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_TX_IDLE;
        end

        default: state <= S_TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_transmitter.sv
// tb/tb_sram_uart_transmitter.sv - directed self-checking bench for sram_uart_transmitter
module tb_sram_uart_transmitter;

  logic CLOCK_50_I;
  logic resetn;
  logic UART_TX_O;

  sram_uart_transmitter_if bus();

  sram_uart_transmitter dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .bus        (bus.slave),
    .UART_TX_O  (UART_TX_O)
  );

  initial CLOCK_50_I = 1'b0;
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  int cyc = 0;
  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: data for the address presented in cycle r is valid in cycle r+2
  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_d1;
  always @(posedge CLOCK_50_I) begin
    rd_d1              <= mem.exists(bus.SRAM_address) ? mem[bus.SRAM_address] : 16'h0000;
    bus.SRAM_read_data <= rd_d1;
  end

  // Monitors
  logic [7:0]  rx_q   [$];
  int          fall_q [$];
  logic [17:0] addr_q [$];
  int          done_cnt = 0;
  int          we_bad   = 0;
  int          stop_err = 0;

  initial begin : line_mon
    logic [17:0] pa;
    pa = '0;
    forever begin
      @(negedge CLOCK_50_I);
      if (bus.SRAM_we_n !== 1'b1) we_bad++;
      if (bus.Done === 1'b1) done_cnt++;
      if (bus.SRAM_address !== pa) begin
        addr_q.push_back(bus.SRAM_address);
        pa = bus.SRAM_address;
      end
    end
  end

  initial begin : uart_rx
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge CLOCK_50_I);
      if (resetn === 1'b1 && prev === 1'b1 && UART_TX_O === 1'b0) begin
        fall_q.push_back(cyc);
        repeat (216) @(negedge CLOCK_50_I);
        if (UART_TX_O !== 1'b0) stop_err++;
        for (int j = 0; j < 8; j++) begin
          repeat (434) @(negedge CLOCK_50_I);
          b[j] = UART_TX_O;
        end
        repeat (434) @(negedge CLOCK_50_I);
        if (UART_TX_O !== 1'b1) stop_err++;
        rx_q.push_back(b);
      end
      prev = UART_TX_O;
    end
  end

  logic [7:0]  exp_b [$];
  logic [17:0] exp_a [$];

  task automatic clear_logs();
    rx_q.delete();
    fall_q.delete();
    addr_q.delete();
  endtask

  task automatic expect_bytes(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_b[i]);
  endtask

  task automatic expect_addrs(input string tag);
    check({tag, "_naddr"}, addr_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      if (i < addr_q.size()) check($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_a[i]);
  endtask

  task automatic start_pulse(input logic [17:0] a, input logic [17:0] n, output int s);
    @(negedge CLOCK_50_I);
    bus.Start_address = a;
    bus.Word_count    = n;
    bus.Start         = 1'b1;
    s = cyc;
    @(negedge CLOCK_50_I);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int busy_low, output int dcyc);
    int k;
    k = 0;
    busy_low = 0;
    while (bus.Done !== 1'b1 && k < budget) begin
      if (bus.Busy !== 1'b1) busy_low++;
      @(negedge CLOCK_50_I);
      k++;
    end
    dcyc = cyc;
    check({tag, "_done_seen"}, bus.Done, 1'b1);
  endtask

  initial begin
    int s, dc, bl, d0, k, f;

    resetn             = 1'b0;
    bus.Start          = 1'b0;
    bus.Start_address  = '0;
    bus.Word_count     = '0;
    mem[18'h00000]     = 16'hA55A;
    mem[18'h3FFFF]     = 16'h1234;
    mem[18'h00001]     = 16'hC3E1;
    mem[18'h00010]     = 16'h8001;
    mem[18'h00011]     = 16'h7E3C;
    mem[18'h00020]     = 16'hFFFF;
    mem[18'h00040]     = 16'h0700;
    mem[18'h00005]     = 16'h00FF;

    repeat (4) @(negedge CLOCK_50_I);
    check("rst_addr", bus.SRAM_address, 18'h0);
    check("rst_we_n", bus.SRAM_we_n, 1'b1);
    check("rst_tx",   UART_TX_O, 1'b1);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);
    check("idle_tx", UART_TX_O, 1'b1);

    // One word from address 0: 0xA5 then 0x5A
    clear_logs();
    start_pulse(18'h0, 18'd1, s);
    check("t1_busy_next", bus.Busy, 1'b1);
    wait_done("t1", 12000, bl, dc);
    check("t1_busy_held", bl, 0);
    exp_b = {8'hA5, 8'h5A};
    expect_bytes("t1");
    if (fall_q.size() == 2) begin
      check("t1_first_start", fall_q[0] - s, 4);
      check("t1_frame_period", fall_q[1] - fall_q[0], 4340);
      check("t1_done_lat", dc - fall_q[1], 4341);
    end else check("t1_nframes", fall_q.size(), 2);
    @(negedge CLOCK_50_I);
    check("t1_done_1cyc", bus.Done, 1'b0);
    check("t1_busy_end", bus.Busy, 1'b0);

    // Three words across the address wrap
    clear_logs();
    d0 = done_cnt;
    start_pulse(18'h3FFFF, 18'd3, s);
    wait_done("t2", 30000, bl, dc);
    check("t2_busy_held", bl, 0);
    repeat (20) @(negedge CLOCK_50_I);
    check("t2_one_done", done_cnt - d0, 1);
    exp_b = {8'h12, 8'h34, 8'hA5, 8'h5A, 8'hC3, 8'hE1};
    expect_bytes("t2");
    exp_a = {18'h3FFFF, 18'h00000, 18'h00001};
    expect_addrs("t2");
    if (fall_q.size() == 6) begin
      check("t2_intra_word", fall_q[3] - fall_q[2], 4340);
      check("t2_inter_word", fall_q[2] - fall_q[1], 4343);
    end else check("t2_nframes", fall_q.size(), 6);

    // Zero words, plus a Start in the Done cycle that must be dropped
    clear_logs();
    d0 = done_cnt;
    start_pulse(18'h00030, 18'd0, s);
    check("t3_busy", bus.Busy, 1'b1);
    @(negedge CLOCK_50_I);
    check("t3_done_lat", cyc - s, 2);
    check("t3_done", bus.Done, 1'b1);
    check("t3_busy_off", bus.Busy, 1'b0);
    bus.Start_address = 18'h00030;
    bus.Word_count    = 18'd1;
    bus.Start         = 1'b1;
    @(negedge CLOCK_50_I);
    bus.Start = 1'b0;
    repeat (10) @(negedge CLOCK_50_I);
    check("t3_start_dropped", bus.Busy, 1'b0);
    check("t3_one_done", done_cnt - d0, 1);
    check("t3_no_read", addr_q.size(), 0);
    check("t3_no_frame", fall_q.size(), 0);
    check("t3_tx_idle", UART_TX_O, 1'b1);

    // Start mid-transmission is ignored
    clear_logs();
    d0 = done_cnt;
    start_pulse(18'h00010, 18'd2, s);
    repeat (2000) @(negedge CLOCK_50_I);
    start_pulse(18'h00020, 18'd5, k);
    wait_done("t4", 20000, bl, dc);
    check("t4_busy_held", bl, 0);
    repeat (50) @(negedge CLOCK_50_I);
    check("t4_one_done", done_cnt - d0, 1);
    check("t4_busy_end", bus.Busy, 1'b0);
    exp_b = {8'h80, 8'h01, 8'h7E, 8'h3C};
    expect_bytes("t4");
    exp_a = {18'h00010, 18'h00011};
    expect_addrs("t4");

    // Reset halfway through data bit 3 of the first frame
    clear_logs();
    d0 = done_cnt;
    start_pulse(18'h00040, 18'd1, s);
    k = 0;
    while (fall_q.size() == 0 && k < 50) begin
      @(negedge CLOCK_50_I);
      k++;
    end
    check("t5_frame_began", fall_q.size(), 1);
    f = (fall_q.size() > 0) ? fall_q[0] : cyc;
    k = 0;
    while (cyc < f + 4 * 434 + 217 && k < 5000) begin
      @(negedge CLOCK_50_I);
      k++;
    end
    check("t5_pre_rst_tx", UART_TX_O, 1'b0);
    #3 resetn = 1'b0;
    #1;
    check("t5_rst_tx",   UART_TX_O, 1'b1);
    check("t5_rst_busy", bus.Busy, 1'b0);
    check("t5_rst_done", bus.Done, 1'b0);
    check("t5_rst_addr", bus.SRAM_address, 18'h0);
    repeat (5) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (5000) @(negedge CLOCK_50_I);
    check("t5_no_done", done_cnt - d0, 0);
    clear_logs();
    start_pulse(18'h00005, 18'd1, s);
    wait_done("t5b", 12000, bl, dc);
    check("t5b_busy_held", bl, 0);
    exp_b = {8'h00, 8'hFF};
    expect_bytes("t5b");
    if (fall_q.size() == 2) begin
      check("t5b_first_start", fall_q[0] - s, 4);
      check("t5b_frame_period", fall_q[1] - fall_q[0], 4340);
    end else check("t5b_nframes", fall_q.size(), 2);
    repeat (10) @(negedge CLOCK_50_I);

    check("stop_bits", stop_err, 0);
    check("we_n_always_1", we_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
